str_sched: RTL and testbench

Round-robin scheduler that shares one expression-string recognizer between N_REQ byte-stream requesters. Each requester presents a string one byte per handshake, terminated by a byte flagged `last`. The scheduler grants the recognizer to one requester for a whole string and restarts the recognizer between strings. It then reports a per-string verdict tagged with the requester id. It sits between the input-producing front ends and the single shared `expr_fsm` instance.

---
 rtl/str_pkg.sv | 37 +++
 rtl/expr_fsm.sv | 38 +++
 rtl/str_sched.sv | 95 +++++++++
 tb/tb_str_sched.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/str_pkg.sv
// Shared types, ASCII constants and helper functions for the string scheduler.
// Holds the round-robin pick so the arbiter stays a single flat FSM.
package str_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
    typedef enum logic [1:0] {START, NUM, OP, ERR} rec_state_t;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_9 = 8'h39;
    localparam int         RR_MAX  = 8;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

    // First requester at or after ptr in cyclic order over n requesters.
    function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] req,
                                           input logic [2:0]        ptr,
                                           input int                n);
        logic [2:0] w_pick;
        logic [2:0] w_idx;
        logic       w_found;
        int         k;
        w_pick  = '0;
        w_found = 1'b0;
        for (int i = 0; i < RR_MAX; i++) begin
            k     = (int'(ptr) + i) % n;
            w_idx = k[2:0];
            if ((i < n) && !w_found && req[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
        return w_pick;
    endfunction

endpackage

// File: rtl/expr_fsm.sv
// Recognizer for digit (nondigit digit)*; one state step per accepted byte.
// restart wins over a concurrent byte; ERR is sticky until restart.
module expr_fsm
    import str_pkg::*;
(
    input  logic       clk,
    input  logic       clr_n,
    input  logic       restart,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       accept
);

    rec_state_t r_state;
    rec_state_t w_next;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) r_state <= START;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (restart) begin
            w_next = START;
        end else if (in_valid) begin
            case (r_state)
                START:   w_next = is_digit(in_byte) ? NUM : ERR;
                NUM:     w_next = is_digit(in_byte) ? ERR : OP;
                OP:      w_next = is_digit(in_byte) ? NUM : ERR;
                default: w_next = ERR;
            endcase
        end
    end

    assign accept = (r_state == NUM);

endmodule

// File: rtl/str_sched.sv
// Round-robin share of one expr_fsm across N_REQ byte streams; grant held for a whole string.
// Grant 1 cycle after request, 1 byte/cycle, verdict 1 cycle after last byte; ready only to the grantee.
module str_sched
    import str_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = $clog2(N_REQ),
    parameter int MAX_LEN = 255
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               res_valid,
    output logic [ID_W-1:0]    res_id,
    output logic               res_ok,
    output logic [7:0]         res_len,
    output logic               busy
);

    arb_state_t      r_state;
    arb_state_t      w_next;
    logic [ID_W-1:0] r_grant;
    logic [ID_W-1:0] r_ptr;
    logic [8:0]      r_cnt;

    logic            w_hs;
    logic            w_last;
    logic [7:0]      w_byte;
    logic [2:0]      w_pick;
    logic            w_accept;
    logic            w_restart;

    assign w_hs      = (r_state == BUSY) && req_valid[r_grant];
    assign w_last    = req_last[r_grant];
    assign w_byte    = req_data[int'(r_grant)*8 +: 8];
    assign w_pick    = rr_pick(8'(req_valid), 3'(r_ptr), N_REQ);
    assign w_restart = (r_state == DONE);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|req_valid)     w_next = BUSY;
            BUSY:    if (w_hs && w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Counter saturates at 256 so anything past 255 still reads as over-length.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_grant <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            if ((r_state == IDLE) && (|req_valid))
                r_grant <= ID_W'(w_pick);
            if (r_state == DONE)
                r_ptr <= (r_grant == ID_W'(N_REQ-1)) ? '0 : r_grant + 1'b1;
            if (r_state == DONE)
                r_cnt <= '0;
            else if (w_hs && (r_cnt != 9'd256))
                r_cnt <= r_cnt + 9'd1;
        end
    end

    expr_fsm u_expr (
        .clk      (clk),
        .clr_n    (clr_n),
        .restart  (w_restart),
        .in_valid (w_hs),
        .in_byte  (w_byte),
        .accept   (w_accept)
    );

    always_comb begin
        req_ready = '0;
        if (r_state == BUSY) req_ready[r_grant] = 1'b1;
    end

    assign res_valid = (r_state == DONE);
    assign res_id    = res_valid ? r_grant : '0;
    assign res_ok    = res_valid && w_accept && (r_cnt <= 9'(MAX_LEN));
    assign res_len   = !res_valid ? 8'd0 : (r_cnt[8] ? 8'hFF : r_cnt[7:0]);
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_str_sched.sv
// Bench for str_sched: directed cycle-exact sequences, a vector table and random
// strings scored against a pattern/round-robin reference model.
module tb_str_sched;

    localparam int N       = 4;
    localparam int MAX_LEN = 3;

    logic         clk = 1'b0;
    logic         clr_n;
    logic [N-1:0] req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0] req_last;
    logic [N-1:0] req_ready;
    logic         res_valid;
    logic [1:0]   res_id;
    logic         res_ok;
    logic [7:0]   res_len;
    logic         busy;

    str_sched #(.N_REQ(N), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_ok    (res_ok),
        .res_len   (res_len),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [8:0] bq [N][$];
    int         eok [N][$];
    int         elen [N][$];
    int         str_left [N];
    bit         first_b [N];
    int         m_ptr;
    int         order_q [$];
    logic [7:0] sbuf [$];

    typedef struct {
        int    id;
        string s;
        int    ok;
        int    len;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic bit is_dig(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    // Reference verdict: odd length, digits on even positions, operators on odd ones.
    function automatic int ref_ok();
        int n = sbuf.size();
        if ((n % 2) == 0 || n > MAX_LEN) return 0;
        for (int k = 0; k < n; k++)
            if (((k % 2) == 0) != is_dig(sbuf[k])) return 0;
        return 1;
    endfunction

    task automatic add_sbuf(input int id, input int ok, input int len);
        for (int k = 0; k < sbuf.size(); k++)
            bq[id].push_back({(k == sbuf.size() - 1), sbuf[k]});
        eok[id].push_back(ok);
        elen[id].push_back(len);
        str_left[id]++;
    endtask

    function automatic int rr_expect();
        for (int k = 0; k < N; k++)
            if (str_left[(m_ptr + k) % N] > 0) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic do_reset();
        clr_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_id", int'(res_id), 0);
        chk("rst_res_ok", int'(res_ok), 0);
        chk("rst_res_len", int'(res_len), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        m_ptr = 0;
        for (int i = 0; i < N; i++) begin
            first_b[i]  = 1'b1;
            str_left[i] = 0;
            bq[i].delete();
            eok[i].delete();
            elen[i].delete();
        end
        order_q.delete();
    endtask

    task automatic drive_all(input bit stall_en);
        logic [8:0] e;
        for (int i = 0; i < N; i++) begin
            if (bq[i].size() > 0) begin
                e = bq[i][0];
                req_valid[i]      = first_b[i] || !stall_en || ($urandom_range(0, 3) != 0);
                req_data[8*i +: 8] = e[7:0];
                req_last[i]       = e[8];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i]       = 1'($urandom);
            end
        end
    endtask

    // Feeds all queued strings as concurrent producers and scores every verdict.
    task automatic run_engine(input bit stall_en, input int budget);
        int         total = 0;
        int         seen  = 0;
        int         cyc   = 0;
        int         eid;
        logic [N-1:0] hsp;
        logic [8:0] e;
        for (int i = 0; i < N; i++) total += str_left[i];
        drive_all(stall_en);
        while (seen < total && cyc < budget) begin
            @(negedge clk);
            if (res_valid) begin
                eid = rr_expect();
                order_q.push_back(int'(res_id));
                chk("res_id", int'(res_id), eid);
                if (eid >= 0) begin
                    chk("res_ok", int'(res_ok), eok[eid].pop_front());
                    chk("res_len", int'(res_len), elen[eid].pop_front());
                    str_left[eid]--;
                    m_ptr = (eid + 1) % N;
                end
                seen++;
            end
            hsp = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hsp[i]) begin
                    e          = bq[i].pop_front();
                    first_b[i] = e[8];
                end
            end
            drive_all(stall_en);
            cyc++;
        end
        chk("engine_results_seen", seen, total);
        req_valid = '0;
        repeat (4) begin
            @(negedge clk);
            chk("no_extra_res", int'(res_valid), 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_order [3];
        int n;
        bit good;

        // Single string "1+2" with exact cycle timing.
        do_reset();
        req_valid[0] = 1'b1; req_data[7:0] = "1"; req_last[0] = 1'b0;
        @(posedge clk); #1;
        chk("t1_grant_ready", int'(req_ready), 1);
        chk("t1_busy", int'(busy), 1);
        chk("t1_no_res", int'(res_valid), 0);
        @(posedge clk); #1; req_data[7:0] = "+";
        @(posedge clk); #1; req_data[7:0] = "2"; req_last[0] = 1'b1;
        @(posedge clk); #1; req_valid[0] = 1'b0; req_last[0] = 1'b0;
        chk("t1_res_valid", int'(res_valid), 1);
        chk("t1_res_id", int'(res_id), 0);
        chk("t1_res_ok", int'(res_ok), 1);
        chk("t1_res_len", int'(res_len), 3);
        chk("t1_ready_done", int'(req_ready), 0);
        @(posedge clk); #1;
        chk("t1_res_valid_off", int'(res_valid), 0);
        chk("t1_idle_busy", int'(busy), 0);

        // Requester 3 stalls for 5 cycles mid "7*8".
        do_reset();
        req_valid[3] = 1'b1; req_data[31:24] = "7";
        @(posedge clk); #1;
        chk("t2_grant_ready", int'(req_ready), 8);
        @(posedge clk); #1; req_valid[3] = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            chk("t2_stall_ready", int'(req_ready), 8);
            chk("t2_stall_busy", int'(busy), 1);
            chk("t2_stall_res", int'(res_valid), 0);
        end
        req_valid[3] = 1'b1; req_data[31:24] = "*";
        @(posedge clk); #1; req_data[31:24] = "8"; req_last[3] = 1'b1;
        @(posedge clk); #1; req_valid[3] = 1'b0; req_last[3] = 1'b0;
        chk("t2_res_valid", int'(res_valid), 1);
        chk("t2_res_id", int'(res_id), 3);
        chk("t2_res_ok", int'(res_ok), 1);
        chk("t2_res_len", int'(res_len), 3);

        // Vector table: several requesters concurrently, per-id order preserved.
        tbl[0] = '{1, "12",    0, 2};
        tbl[1] = '{1, "+",     0, 1};
        tbl[2] = '{0, "1+2",   1, 3};
        tbl[3] = '{2, "9",     1, 1};
        tbl[4] = '{3, "1+2+3", 0, 5};
        tbl[5] = '{0, "4/5",   1, 3};
        tbl[6] = '{2, "a",     0, 1};
        tbl[7] = '{3, "12+",   0, 3};
        tbl[8] = '{2, "0-9",   1, 3};
        tbl[9] = '{1, "3*",    0, 2};
        do_reset();
        for (int t = 0; t < 10; t++) begin
            sbuf.delete();
            for (int k = 0; k < tbl[t].s.len(); k++) sbuf.push_back(tbl[t].s[k]);
            add_sbuf(tbl[t].id, tbl[t].ok, tbl[t].len);
        end
        run_engine(1'b0, 500);

        // Fairness: 0 re-requests during its DONE cycle, 2 must go first.
        do_reset();
        sbuf.delete(); sbuf.push_back("1"); add_sbuf(0, 1, 1);
        sbuf.delete(); sbuf.push_back("2"); add_sbuf(2, 1, 1);
        sbuf.delete(); sbuf.push_back("3"); add_sbuf(0, 1, 1);
        run_engine(1'b0, 100);
        exp_order = '{0, 2, 0};
        chk("rr_order_count", order_q.size(), 3);
        for (int k = 0; k < 3 && k < order_q.size(); k++)
            chk("rr_order", order_q[k], exp_order[k]);

        // 300 alternating bytes: length saturates, over-length rejected.
        do_reset();
        sbuf.delete();
        for (int k = 0; k < 300; k++) sbuf.push_back((k % 2) == 0 ? 8'h35 : 8'h2B);
        add_sbuf(1, 0, 255);
        run_engine(1'b0, 400);

        // Reset mid "5-6": partial string dropped, resend accepted.
        do_reset();
        req_valid[0] = 1'b1; req_data[7:0] = "5";
        @(posedge clk); #1;
        @(posedge clk); #1; req_data[7:0] = "-";
        @(posedge clk); #1; req_data[7:0] = "6"; req_last[0] = 1'b1;
        #2 clr_n = 1'b0;
        #1;
        chk("clr_ready", int'(req_ready), 0);
        chk("clr_busy", int'(busy), 0);
        repeat (3) begin
            @(negedge clk);
            chk("clr_no_res", int'(res_valid), 0);
        end
        req_valid = '0; req_last = '0;
        @(negedge clk); clr_n = 1'b1;
        @(posedge clk); #1;
        sbuf.delete(); sbuf.push_back("5"); sbuf.push_back("-"); sbuf.push_back("6");
        add_sbuf(0, 1, 3);
        run_engine(1'b0, 100);

        // Random strings with random mid-string stalls.
        for (int round = 0; round < 3; round++) begin
            do_reset();
            for (int id = 0; id < N; id++) begin
                for (int s = 0; s < int'($urandom_range(1, 3)); s++) begin
                    n    = $urandom_range(1, 6);
                    good = ($urandom_range(0, 9) < 7);
                    sbuf.delete();
                    for (int k = 0; k < n; k++) begin
                        if (!good)
                            sbuf.push_back(8'($urandom_range(8'h28, 8'h3F)));
                        else if ((k % 2) == 0)
                            sbuf.push_back(8'(8'h30 + $urandom_range(0, 9)));
                        else
                            sbuf.push_back(8'h2A + 8'($urandom_range(0, 1)));
                    end
                    add_sbuf(id, ref_ok(), (n > 255) ? 255 : n);
                end
            end
            run_engine(1'b1, 2000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
